player_damage_ctrl: RTL and testbench

Producer side of the player hit interface. It detects pixel-level overlap between the player and explosions or enemies during a frame and decides whether the overlap costs a life. Once per frame it issues a one-cycle player_hit pulse to the player hit/blink controller and tracks lives and game-over. It uses the controller's player_invulnerable output as feedback, so collisions are ignored while the player is flashing.

---
 rtl/bomberman_pkg.sv | 17 +
 rtl/collision_frame_latch.sv | 34 +++
 rtl/player_damage_ctrl.sv | 115 +++++++++++
 tb/tb_player_damage_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bomberman_pkg.sv
// rtl/bomberman_pkg.sv - shared types and constants for the player damage path
package bomberman_pkg;

   typedef enum logic [1:0] {
      ALIVE_ST     = 2'd0,
      HIT_ST       = 2'd1,
      PROTECTED_ST = 2'd2,
      DEAD_ST      = 2'd3
   } damage_state_t;

   localparam logic [1:0] HIT_SRC_EXPL  = 2'b01;
   localparam logic [1:0] HIT_SRC_ENEMY = 2'b10;

   localparam int LIVES_INIT_DEF = 3;
   localparam int MAX_LIVES_DEF  = 7;

endpackage

// File: rtl/collision_frame_latch.sv
// rtl/collision_frame_latch.sv - sticky per-frame explosion/enemy overlap flags
module collision_frame_latch (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic start_of_frame,
   input  logic player_dr,
   input  logic explosion_dr,
   input  logic enemy_dr,
   output logic expl_flag,
   output logic enemy_flag
);

   logic expl_hit;
   logic enemy_hit;

   assign expl_hit  = player_dr && explosion_dr;
   assign enemy_hit = player_dr && enemy_dr;

   // A collision on the start-of-frame cycle seeds the next frame instead of the one being judged.
   always_ff @(posedge clk) begin
      if (reset || !enable) begin
         expl_flag  <= 1'b0;
         enemy_flag <= 1'b0;
      end else if (start_of_frame) begin
         expl_flag  <= expl_hit;
         enemy_flag <= enemy_hit;
      end else begin
         expl_flag  <= expl_flag  || expl_hit;
         enemy_flag <= enemy_flag || enemy_hit;
      end
   end

endmodule

// File: rtl/player_damage_ctrl.sv
// rtl/player_damage_ctrl.sv - per-frame hit decision, lives counter and game-over tracking
module player_damage_ctrl
   import bomberman_pkg::*;
#(
   parameter int LIVES_INIT  = bomberman_pkg::LIVES_INIT_DEF,
   parameter int MAX_LIVES   = bomberman_pkg::MAX_LIVES_DEF,
   parameter int LIVES_W     = 3,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               player_dr,
   input  logic               explosion_dr,
   input  logic               enemy_dr,
   input  logic               player_invulnerable,
   input  logic               extra_life,
   input  logic               restart,
   output logic               player_hit,
   output logic [LIVES_W-1:0] lives,
   output logic               game_over,
   output logic [1:0]         hit_source
);

   localparam int TIMER_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
   localparam logic [LIVES_W-1:0] LIVES_MAX = LIVES_W'(MAX_LIVES);
   localparam logic [TIMER_W-1:0] TIMER_END = TIMER_W'(ACK_TIMEOUT);

   damage_state_t      state;
   logic [TIMER_W-1:0] timer;
   logic               expl_flag;
   logic               enemy_flag;
   logic               latch_en;
   logic               evaluate;
   logic [LIVES_W-1:0] lives_dec;
   logic [LIVES_W-1:0] lives_next;

   assign latch_en = (state == ALIVE_ST) && !player_invulnerable;
   assign evaluate = latch_en && startOfFrame && (expl_flag || enemy_flag);

   collision_frame_latch u_latch (
      .clk            (clk),
      .reset          (reset || restart),
      .enable         (latch_en),
      .start_of_frame (startOfFrame),
      .player_dr      (player_dr),
      .explosion_dr   (explosion_dr),
      .enemy_dr       (enemy_dr),
      .expl_flag      (expl_flag),
      .enemy_flag     (enemy_flag)
   );

   // Decrement first, then the bonus, so a bonus on the fatal frame keeps the player alive.
   always_comb begin
      lives_dec  = lives;
      lives_next = lives;
      if (evaluate && lives != '0) begin
         lives_dec = lives - 1'b1;
      end
      lives_next = lives_dec;
      if (extra_life && state != DEAD_ST && lives_dec < LIVES_MAX) begin
         lives_next = lives_dec + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || restart) begin
         state      <= ALIVE_ST;
         lives      <= LIVES_RST;
         player_hit <= 1'b0;
         game_over  <= 1'b0;
         hit_source <= 2'b00;
         timer      <= '0;
      end else begin
         player_hit <= 1'b0;
         lives      <= lives_next;
         case (state)
            ALIVE_ST: begin
               if (evaluate) begin
                  player_hit <= 1'b1;
                  hit_source <= (enemy_flag ? HIT_SRC_ENEMY : 2'b00) |
                                (expl_flag  ? HIT_SRC_EXPL  : 2'b00);
                  timer      <= '0;
                  if (lives_next == '0) begin
                     state     <= DEAD_ST;
                     game_over <= 1'b1;
                  end else begin
                     state <= HIT_ST;
                  end
               end
            end
            HIT_ST: begin
               // The timeout keeps a silent hit controller from freezing damage forever.
               if (player_invulnerable) begin
                  state <= PROTECTED_ST;
               end else if (timer == TIMER_END) begin
                  state <= ALIVE_ST;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            PROTECTED_ST: begin
               if (!player_invulnerable) begin
                  state <= ALIVE_ST;
               end
            end
            default: begin
               game_over <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_player_damage_ctrl.sv
// tb/tb_player_damage_ctrl.sv - vector table, corner sequences and random run against a reference model
module tb_player_damage_ctrl;

   localparam int ACK  = 15;
   localparam int MAXL = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, sof, pd, xd, ed, inv, xl, rs;
   logic       hit3, go3, hit1, go1;
   logic [2:0] lives3, lives1;
   logic [1:0] src3, src1;

   int n_cmp = 0;
   int n_bad = 0;

   player_damage_ctrl #(.LIVES_INIT(3)) dut3 (
      .clk(clk), .reset(reset), .startOfFrame(sof), .player_dr(pd),
      .explosion_dr(xd), .enemy_dr(ed), .player_invulnerable(inv),
      .extra_life(xl), .restart(rs), .player_hit(hit3), .lives(lives3),
      .game_over(go3), .hit_source(src3)
   );

   player_damage_ctrl #(.LIVES_INIT(1)) dut1 (
      .clk(clk), .reset(reset), .startOfFrame(sof), .player_dr(pd),
      .explosion_dr(xd), .enemy_dr(ed), .player_invulnerable(inv),
      .extra_life(xl), .restart(rs), .player_hit(hit1), .lives(lives1),
      .game_over(go1), .hit_source(src1)
   );

   // phase: 0 vulnerable, 1 waiting for the blink controller, 2 blinking, 3 game over
   typedef struct {
      int lives;
      bit go;
      int phase;
      int waited;
      bit seen_expl;
      bit seen_enemy;
      bit hit;
      int src;
   } mdl_t;

   mdl_t m3, m1;

   function automatic mdl_t mstep(mdl_t m, int init, bit rst, bit s, bit p, bit x,
                                  bit e, bit iv, bit el, bit r);
      mdl_t n = m;
      bit listening = (m.phase == 0) && !iv;
      n.hit = 1'b0;
      if (rst || r) begin
         n.lives = init; n.go = 0; n.phase = 0; n.waited = 0;
         n.seen_expl = 0; n.seen_enemy = 0; n.src = 0;
         return n;
      end
      if (listening && s && (m.seen_expl || m.seen_enemy)) begin
         n.hit = 1'b1;
         n.src = (m.seen_enemy ? 2 : 0) + (m.seen_expl ? 1 : 0);
         if (n.lives > 0) n.lives = n.lives - 1;
         if (el) n.lives = (n.lives + 1 > MAXL) ? MAXL : n.lives + 1;
         if (n.lives == 0) begin
            n.phase = 3; n.go = 1;
         end else begin
            n.phase = 1; n.waited = 0;
         end
      end else begin
         if (el && m.phase != 3) n.lives = (n.lives + 1 > MAXL) ? MAXL : n.lives + 1;
         if (m.phase == 1) begin
            if (iv) n.phase = 2;
            else if (m.waited == ACK) n.phase = 0;
            else n.waited = m.waited + 1;
         end else if (m.phase == 2) begin
            if (!iv) n.phase = 0;
         end
      end
      if (!listening) begin
         n.seen_expl = 0; n.seen_enemy = 0;
      end else if (s) begin
         n.seen_expl = p && x; n.seen_enemy = p && e;
      end else begin
         n.seen_expl = m.seen_expl || (p && x);
         n.seen_enemy = m.seen_enemy || (p && e);
      end
      return n;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step(input bit rst_i, input bit s_i, input bit p_i, input bit x_i,
                       input bit e_i, input bit iv_i, input bit el_i, input bit r_i);
      reset = rst_i; sof = s_i; pd = p_i; xd = x_i; ed = e_i;
      inv = iv_i; xl = el_i; rs = r_i;
      @(posedge clk);
      m3 = mstep(m3, 3, rst_i, s_i, p_i, x_i, e_i, iv_i, el_i, r_i);
      m1 = mstep(m1, 1, rst_i, s_i, p_i, x_i, e_i, iv_i, el_i, r_i);
      #1;
      check("hit3", int'(hit3), int'(m3.hit));
      check("lives3", int'(lives3), m3.lives);
      check("go3", int'(go3), int'(m3.go));
      check("src3", int'(src3), m3.src);
      check("hit1", int'(hit1), int'(m1.hit));
      check("lives1", int'(lives1), m1.lives);
      check("go1", int'(go1), int'(m1.go));
      check("src1", int'(src1), m1.src);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   typedef struct {
      bit rst, s, p, x, e, iv, el, r;
      int hit, lives, go, src;
   } vec_t;

   vec_t tbl[14];

   initial begin
      int cnt;
      bit iv_r;
      reset = 1; sof = 0; pd = 0; xd = 0; ed = 0; inv = 0; xl = 0; rs = 0;

      //           rst s p x e iv el r   hit lives go src
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 3, 0, 0};
      tbl[1]  = '{0, 0, 1, 1, 0, 0, 0, 0,  0, 3, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0,  1, 2, 0, 1};
      tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1};
      tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 0,  0, 2, 0, 1};
      tbl[5]  = '{0, 0, 1, 0, 1, 1, 0, 0,  0, 2, 0, 1};
      tbl[6]  = '{0, 1, 1, 1, 1, 1, 0, 0,  0, 2, 0, 1};
      tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 1};
      tbl[8]  = '{0, 0, 1, 0, 1, 0, 0, 0,  0, 2, 0, 1};
      tbl[9]  = '{0, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 2};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 1, 0,  0, 2, 0, 2};
      tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1,  0, 3, 0, 0};
      tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 0,  0, 4, 0, 0};
      tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 0,  0, 5, 0, 0};

      for (int i = 0; i < 14; i++) begin
         step(tbl[i].rst, tbl[i].s, tbl[i].p, tbl[i].x, tbl[i].e, tbl[i].iv, tbl[i].el, tbl[i].r);
         check("tbl_hit", int'(hit3), tbl[i].hit);
         check("tbl_lives", int'(lives3), tbl[i].lives);
         check("tbl_go", int'(go3), tbl[i].go);
         check("tbl_src", int'(src3), tbl[i].src);
      end

      // invulnerability window masks every overlap
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check("inv_first_hit", int'(hit3), 1);
      idle(3);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         step(0, (i % 10) == 9, 1, 1, 1, 1, 0, 0);
         cnt += int'(hit3);
      end
      check("inv_no_hit", cnt, 0);
      check("inv_lives", int'(lives3), 2);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check("post_inv_hit", int'(hit3), 1);
      check("post_inv_lives", int'(lives3), 1);

      // 500 overlapping pixels of both kinds cost one life
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 500; i++) step(0, 0, 1, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      cnt = int'(hit3);
      check("both_src", int'(src3), 3);
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 0);
         cnt += int'(hit3);
      end
      check("both_one_hit", cnt, 1);
      check("both_lives", int'(lives3), 2);

      // fatal hit on the single-life instance, then everything ignored until restart
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check("fatal_hit", int'(hit1), 1);
      check("fatal_lives", int'(lives1), 0);
      check("fatal_go", int'(go1), 1);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         step(0, (i % 5) == 4, 1, 1, 1, 0, (i % 3) == 0, 0);
         cnt += int'(hit1);
      end
      check("dead_no_hit", cnt, 0);
      check("dead_lives", int'(lives1), 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      check("restart_lives", int'(lives1), 1);
      check("restart_go", int'(go1), 0);

      // bonus on the fatal frame, then saturation
      step(0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 1, 0);
      check("bonus_hit", int'(hit1), 1);
      check("bonus_lives", int'(lives1), 1);
      check("bonus_go", int'(go1), 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
      check("sat_lives", int'(lives3), 7);

      // unanswered hit times out back to vulnerable
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      idle(5);
      step(0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check("wait_ignored_hit", int'(hit3), 0);
      idle(15);
      step(0, 0, 1, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0, 0, 0);
      check("timeout_hit", int'(hit3), 1);
      check("timeout_lives", int'(lives3), 1);

      // reset during the wait and on the judging cycle
      step(0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      check("rst_hit_lives", int'(lives3), 3);
      step(0, 0, 1, 1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0);
      check("rst_sof_hit", int'(hit3), 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_sof_after", int'(hit3), 0);
      check("rst_sof_lives", int'(lives3), 3);

      // random traffic against the model
      iv_r = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 29) == 0) iv_r = !iv_r;
         step($urandom_range(0, 899) == 0, $urandom_range(0, 39) == 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 9) == 0, iv_r, $urandom_range(0, 59) == 0,
              $urandom_range(0, 499) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
